// File: rtl/out_layer_ctrl.sv
// Output-layer sequencer: sweeps a shared ROM/activation address, accumulates ten
// dot products in parallel, saturates them and picks the winning class by argmax.
module out_layer_ctrl #(
  parameter int INT_BITS = 5,
  parameter int FRC_BITS = 7,
  parameter int NUM_IN   = 64,
  parameter int NUM_OUT  = 10,
  localparam int W = INT_BITS + FRC_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [9:0]           rom_addr,
  output logic [9:0]           act_addr,
  input  logic [NUM_OUT*W-1:0] w_data,
  input  logic [W-1:0]         act_data,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           class_idx,
  output logic [W-1:0]         max_score
);

  // Handshake: start is sampled only in IDLE; busy is high from the cycle after
  // acceptance through the done cycle; done is a one-cycle pulse with class_idx and
  // max_score already valid, and those hold until the next done.

  localparam int ACC_W = 2*W + $clog2(NUM_IN) + 1;
  localparam logic [9:0] LAST_ADDR = 10'(NUM_IN - 1);
  localparam logic [3:0] LAST_J    = 4'(NUM_OUT - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2**(W-1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_ARGMAX, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [9:0]                addr_cnt_q, addr_cnt_d;
  logic                      vld_q, vld_d;
  logic signed [ACC_W-1:0]   acc_q [NUM_OUT];
  logic signed [ACC_W-1:0]   acc_d [NUM_OUT];
  logic [3:0]                j_q, j_d;
  logic signed [W-1:0]       best_q, best_d;
  logic [3:0]                best_idx_q, best_idx_d;
  logic [3:0]                class_idx_q, class_idx_d;
  logic [W-1:0]              max_score_q, max_score_d;
  logic signed [W-1:0]       score [NUM_OUT];
  logic signed [2*W-1:0]     prod  [NUM_OUT];
  logic [9:0]                addr_c;

  function automatic logic signed [W-1:0] sat_w(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] sh;
    sh = a >>> FRC_BITS;
    if (sh > SAT_HI)      sat_w = SAT_HI[W-1:0];
    else if (sh < SAT_LO) sat_w = SAT_LO[W-1:0];
    else                  sat_w = sh[W-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_OUT; i++) begin
      prod[i]  = $signed(w_data[i*W +: W]) * $signed(act_data);
      score[i] = sat_w(acc_q[i]);
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_cnt_d  = addr_cnt_q;
    vld_d       = 1'b0;
    j_d         = j_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    class_idx_d = class_idx_q;
    max_score_d = max_score_q;
    addr_c      = '0;
    done        = 1'b0;
    // vld_q marks the cycle where the data for last cycle's address is on the bus.
    for (int i = 0; i < NUM_OUT; i++) begin
      acc_d[i] = acc_q[i];
      if (vld_q) acc_d[i] = acc_q[i] + $signed({{(ACC_W-2*W){prod[i][2*W-1]}}, prod[i]});
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FETCH;
          addr_cnt_d = '0;
          for (int i = 0; i < NUM_OUT; i++) acc_d[i] = '0;
        end
      end
      S_FETCH: begin
        addr_c = addr_cnt_q;
        vld_d  = 1'b1;
        if (addr_cnt_q == LAST_ADDR) state_d = S_DRAIN;
        else                         addr_cnt_d = addr_cnt_q + 10'd1;
      end
      S_DRAIN: begin
        addr_c  = addr_cnt_q;
        state_d = S_ARGMAX;
        j_d     = '0;
      end
      S_ARGMAX: begin
        // Strict compare keeps the lowest index on ties.
        if (j_q == 4'd0 || score[j_q] > best_q) begin
          best_d     = score[j_q];
          best_idx_d = j_q;
        end
        if (j_q == LAST_J) begin
          state_d     = S_DONE;
          class_idx_d = best_idx_d;
          max_score_d = best_d;
        end else begin
          j_d = j_q + 4'd1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_cnt_q  <= '0;
      vld_q       <= 1'b0;
      j_q         <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      class_idx_q <= '0;
      max_score_q <= '0;
      for (int i = 0; i < NUM_OUT; i++) acc_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      addr_cnt_q  <= addr_cnt_d;
      vld_q       <= vld_d;
      j_q         <= j_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      class_idx_q <= class_idx_d;
      max_score_q <= max_score_d;
      for (int i = 0; i < NUM_OUT; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign rom_addr  = addr_c;
  assign act_addr  = addr_c;
  assign busy      = (state_q != S_IDLE);
  assign class_idx = class_idx_q;
  assign max_score = max_score_q;

endmodule

// File: tb/tb_out_layer_ctrl.sv
// Directed bench for out_layer_ctrl: a 64-input instance and a 4-input instance share
// behavioural weight/activation memories with one cycle of read latency.
module tb_out_layer_ctrl;
  localparam int W  = 12;
  localparam int NO = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            start_a, start_b;
  logic [9:0]      rom_addr_a, act_addr_a, rom_addr_b, act_addr_b;
  logic [NO*W-1:0] w_data_a, w_data_b;
  logic [W-1:0]    act_data_a, act_data_b;
  logic            busy_a, done_a, busy_b, done_b;
  logic [3:0]      class_a, class_b;
  logic [W-1:0]    score_a, score_b;

  logic [W-1:0] wmem [NO][1024];
  logic [W-1:0] amem [1024];

  int checks = 0;
  int errors = 0;

  out_layer_ctrl #(.NUM_IN(64)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .rom_addr(rom_addr_a), .act_addr(act_addr_a),
    .w_data(w_data_a), .act_data(act_data_a), .busy(busy_a), .done(done_a),
    .class_idx(class_a), .max_score(score_a));

  out_layer_ctrl #(.NUM_IN(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .rom_addr(rom_addr_b), .act_addr(act_addr_b),
    .w_data(w_data_b), .act_data(act_data_b), .busy(busy_b), .done(done_b),
    .class_idx(class_b), .max_score(score_b));

  always @(posedge clk) begin
    for (int i = 0; i < NO; i++) begin
      w_data_a[i*W +: W] <= wmem[i][rom_addr_a];
      w_data_b[i*W +: W] <= wmem[i][rom_addr_b];
    end
    act_data_a <= amem[act_addr_a];
    act_data_b <= amem[act_addr_b];
  end

  task automatic fill(input logic [W-1:0] wv, input logic [W-1:0] av);
    for (int a = 0; a < 1024; a++) begin
      amem[a] = av;
      for (int i = 0; i < NO; i++) wmem[i][a] = wv;
    end
  endtask

  // Pulses start on one instance and watches a fixed window of cycles after E0.
  task automatic run_dut(input bit sel, input int window, output int first_done,
                         output int n_done, output logic [3:0] cls, output logic [W-1:0] sc);
    first_done = -1;
    n_done     = 0;
    cls        = 'x;
    sc         = 'x;
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= window; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      if (sel ? done_b : done_a) begin
        n_done++;
        if (first_done < 0) begin
          first_done = c;
          cls = sel ? class_b : class_a;
          sc  = sel ? score_b : score_a;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy_a !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %0h expected 0", busy_a); end
    checks++; if (done_a !== 1'b0)   begin errors++; $display("FAIL reset_done: got %0h expected 0", done_a); end
    checks++; if (rom_addr_a !== 10'd0) begin errors++; $display("FAIL reset_rom_addr: got %0h expected 0", rom_addr_a); end
    checks++; if (act_addr_a !== 10'd0) begin errors++; $display("FAIL reset_act_addr: got %0h expected 0", act_addr_a); end
    checks++; if (class_a !== 4'd0)  begin errors++; $display("FAIL reset_class: got %0h expected 0", class_a); end
    checks++; if (score_a !== 12'h0) begin errors++; $display("FAIL reset_score: got %0h expected 0", score_a); end
    checks++; if (busy_b !== 1'b0)   begin errors++; $display("FAIL reset_busy_b: got %0h expected 0", busy_b); end
    rst = 1'b0;
  endtask

  task automatic test_all_ones;
    int fd, nd; logic [3:0] cls; logic [W-1:0] sc;
    fill(12'h080, 12'h080);
    run_dut(1'b0, 90, fd, nd, cls, sc);
    checks++; if (fd !== 76)        begin errors++; $display("FAIL ones_latency: got %0d expected 76", fd); end
    checks++; if (nd !== 1)         begin errors++; $display("FAIL ones_done_count: got %0d expected 1", nd); end
    checks++; if (cls !== 4'd0)     begin errors++; $display("FAIL ones_class: got %0h expected 0", cls); end
    checks++; if (sc !== 12'h7FF)   begin errors++; $display("FAIL ones_score: got %0h expected 7ff", sc); end
    checks++; if (busy_a !== 1'b0)  begin errors++; $display("FAIL ones_busy_after: got %0h expected 0", busy_a); end
    checks++; if (score_a !== 12'h7FF) begin errors++; $display("FAIL ones_score_hold: got %0h expected 7ff", score_a); end
  endtask

  task automatic test_single_neuron;
    int fd, nd; logic [3:0] cls; logic [W-1:0] sc;
    fill(12'h000, 12'h080);
    for (int a = 0; a < 1024; a++) wmem[7][a] = 12'h040;
    run_dut(1'b1, 30, fd, nd, cls, sc);
    checks++; if (fd !== 16)      begin errors++; $display("FAIL single_latency: got %0d expected 16", fd); end
    checks++; if (nd !== 1)       begin errors++; $display("FAIL single_done_count: got %0d expected 1", nd); end
    checks++; if (cls !== 4'd7)   begin errors++; $display("FAIL single_class: got %0h expected 7", cls); end
    checks++; if (sc !== 12'h100) begin errors++; $display("FAIL single_score: got %0h expected 100", sc); end
  endtask

  task automatic test_neg_clamp;
    int fd, nd; logic [3:0] cls; logic [W-1:0] sc;
    fill(12'hF80, 12'h7FF);
    run_dut(1'b0, 90, fd, nd, cls, sc);
    checks++; if (fd !== 76)      begin errors++; $display("FAIL neg_latency: got %0d expected 76", fd); end
    checks++; if (cls !== 4'd0)   begin errors++; $display("FAIL neg_class: got %0h expected 0", cls); end
    checks++; if (sc !== 12'h800) begin errors++; $display("FAIL neg_score: got %0h expected 800", sc); end
  endtask

  task automatic test_argmax;
    int fd, nd; logic [3:0] cls; logic [W-1:0] sc;
    logic [W-1:0] wv1 [NO];
    wv1 = '{12'hFF0, 12'hF00, 12'h020, 12'hF00, 12'hF00, 12'h020, 12'hF00, 12'h010, 12'hFFF, 12'h01F};
    fill(12'h000, 12'h080);
    for (int a = 0; a < 1024; a++) for (int i = 0; i < NO; i++) wmem[i][a] = wv1[i];
    run_dut(1'b1, 30, fd, nd, cls, sc);
    checks++; if (cls !== 4'd2)   begin errors++; $display("FAIL tie_class: got %0h expected 2", cls); end
    checks++; if (sc !== 12'h080) begin errors++; $display("FAIL tie_score: got %0h expected 080", sc); end
    for (int a = 0; a < 1024; a++) for (int i = 0; i < NO; i++) wmem[i][a] = (i == 9) ? 12'h7FF : 12'h1FF;
    run_dut(1'b1, 30, fd, nd, cls, sc);
    checks++; if (cls !== 4'd9)   begin errors++; $display("FAIL last_class: got %0h expected 9", cls); end
    checks++; if (sc !== 12'h7FF) begin errors++; $display("FAIL last_score: got %0h expected 7ff", sc); end
  endtask

  task automatic test_address;
    int nd, fd; logic [9:0] exp_addr; logic exp_busy; logic [3:0] cls; logic [W-1:0] sc;
    fill(12'h000, 12'h000);
    amem[5]    = 12'h080;
    wmem[3][5] = 12'h100;
    wmem[4][6] = 12'h7FF;
    wmem[2][4] = 12'h7FF;
    nd = 0; fd = -1; cls = 'x; sc = 'x;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start_a  = (c == 30);
      exp_addr = (c <= 64) ? 10'(c - 1) : ((c == 65) ? 10'd63 : 10'd0);
      exp_busy = (c <= 76);
      checks++; if (rom_addr_a !== exp_addr) begin errors++; $display("FAIL addr_rom c=%0d: got %0d expected %0d", c, rom_addr_a, exp_addr); end
      checks++; if (act_addr_a !== exp_addr) begin errors++; $display("FAIL addr_act c=%0d: got %0d expected %0d", c, act_addr_a, exp_addr); end
      checks++; if (busy_a !== exp_busy)     begin errors++; $display("FAIL addr_busy c=%0d: got %0h expected %0h", c, busy_a, exp_busy); end
      if (done_a) begin
        nd++;
        if (fd < 0) begin fd = c; cls = class_a; sc = score_a; end
      end
    end
    start_a = 1'b0;
    checks++; if (nd !== 1)       begin errors++; $display("FAIL addr_done_count: got %0d expected 1", nd); end
    checks++; if (fd !== 76)      begin errors++; $display("FAIL addr_latency: got %0d expected 76", fd); end
    checks++; if (cls !== 4'd3)   begin errors++; $display("FAIL addr_pair_class: got %0h expected 3", cls); end
    checks++; if (sc !== 12'h100) begin errors++; $display("FAIL addr_pair_score: got %0h expected 100", sc); end
  endtask

  task automatic test_reset_mid;
    int fd, nd; logic [3:0] cls; logic [W-1:0] sc;
    fill(12'h080, 12'h080);
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy_a !== 1'b0)      begin errors++; $display("FAIL mid_busy: got %0h expected 0", busy_a); end
    checks++; if (rom_addr_a !== 10'd0) begin errors++; $display("FAIL mid_rom_addr: got %0h expected 0", rom_addr_a); end
    checks++; if (class_a !== 4'd0)     begin errors++; $display("FAIL mid_class: got %0h expected 0", class_a); end
    checks++; if (score_a !== 12'h0)    begin errors++; $display("FAIL mid_score: got %0h expected 0", score_a); end
    checks++; if (done_a !== 1'b0)      begin errors++; $display("FAIL mid_done: got %0h expected 0", done_a); end
    rst = 1'b0;
    nd = 0;
    for (int c = 0; c < 90; c++) begin
      @(negedge clk);
      if (done_a) nd++;
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL mid_no_done: got %0d expected 0", nd); end
    run_dut(1'b0, 90, fd, nd, cls, sc);
    checks++; if (fd !== 76)      begin errors++; $display("FAIL rerun_latency: got %0d expected 76", fd); end
    checks++; if (cls !== 4'd0)   begin errors++; $display("FAIL rerun_class: got %0h expected 0", cls); end
    checks++; if (sc !== 12'h7FF) begin errors++; $display("FAIL rerun_score: got %0h expected 7ff", sc); end
  endtask

  initial begin
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    fill(12'h000, 12'h000);
    test_reset();
    test_all_ones();
    test_single_neuron();
    test_neg_clamp();
    test_argmax();
    test_address();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/out_layer_ctrl.md
# out_layer_ctrl

Sequencer for the output (classification) layer of the fixed-point network. It sweeps a shared address across the ten output-neuron weight ROMs and the hidden-layer activation buffer, and accumulates ten dot products in parallel. It then saturates each sum to the datapath format and selects the winning class by sequential argmax. The block sits between the hidden-layer activation memory and the top-level result/handshake logic.

## Interface
- INT_BITS, 5, integer bits of weights/activations/scores (signed, two's complement)
- FRC_BITS, 7, fractional bits; W = INT_BITS+FRC_BITS
- NUM_IN, 64, hidden-layer size = number of addresses swept (1..1024)
- NUM_OUT, 10, output neurons/ROM instances; fixed at 10 for this design

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request one inference; sampled only in IDLE
- rom_addr  out  10  shared address to all weight ROMs
- act_addr  out  10  address to activation buffer; always equal to rom_addr
- w_data  in  NUM_OUT*W  packed ROM outputs; neuron i at bits [i*W +: W]; valid 1 cycle after address
- act_data  in  W  activation; valid 1 cycle after act_addr
- busy  out  1  high from start acceptance until done cycle inclusive
- done  out  1  one-cycle pulse, result valid
- class_idx  out  4  index of winning neuron
- max_score  out  W  saturated score of winning neuron

## Operation
- FSM states: IDLE, FETCH, DRAIN, ARGMAX, DONE.
- IDLE: rom_addr=0, busy=0. When start=1, clear all accumulators, set addr_cnt=0, and go to FETCH.
- FETCH: drive rom_addr=addr_cnt and increment it each cycle. After the cycle with addr_cnt=NUM_IN-1, go to DRAIN. rom_addr holds NUM_IN-1 through DRAIN, then returns to 0.
- Accumulate: register a 1-cycle-delayed valid flag alongside the address. In each cycle where the delayed valid is set, acc_i += w_i * act_data for all i in parallel. Operands are signed W x W, giving a 2W-bit full-precision product.
- Accumulator width is ACC_W = 2W + clog2(NUM_IN) + 1. It does not overflow for any input.
- DRAIN: one cycle to absorb the final ROM read; the last product is accumulated on the DRAIN->ARGMAX edge.
- Score: score_i = sat_W(acc_i >>> FRC_BITS), using an arithmetic shift.
  - sat_W clamps to 2^(W-1)-1 (0x7FF at default) or -2^(W-1) (0x800).
- ARGMAX: runs NUM_OUT cycles with index j=0..9.
  - j=0 loads best=score_0, best_idx=0.
  - For j>0, update only if score_j > best (strict compare). Ties therefore resolve to the lowest index.
- DONE: copy best/best_idx to max_score/class_idx, pulse done=1 for one cycle, return to IDLE.
- class_idx/max_score hold their values until the next DONE.
- start while busy is ignored; no queuing.
- start high in the DONE cycle is ignored. start held high continuously re-triggers on the first IDLE cycle.
- rst at any time, including mid-sweep:
  - all state goes to IDLE and accumulators clear;
  - rom_addr=0, busy=0, done=0, class_idx=0, max_score=0;
  - no done pulse is generated for the aborted run.

## Timing
- Edge E0 samples start=1 in IDLE. FETCH covers cycles 1..NUM_IN with rom_addr=0..NUM_IN-1.
- DRAIN is cycle NUM_IN+1. ARGMAX covers cycles NUM_IN+2..NUM_IN+11. done is high in cycle NUM_IN+12.
- Latency from start sample to done is NUM_IN+12 cycles (76 at defaults).
- Earliest next start is sampled in cycle NUM_IN+13, which is the first cycle back in IDLE.
- Both memories are assumed to have exactly 1 cycle of read latency, registered on the same clk. No backpressure exists.
- busy rises the cycle after E0 and falls the cycle after done.

## Test plan
- All weights 0x080 (1.0), all activations 0x080, NUM_IN=64 -> every acc=64.0. All scores saturate to 0x7FF, class_idx=0 (tie rule), done at cycle 76.
- Weights for neuron 7 = 0x040 (0.5), all others 0x000; activations 0x080, NUM_IN=4 -> score_7=0x100 (2.0), others 0. Expect class_idx=7, max_score=0x100, done 16 cycles after start.
- All weights 0xF80 (-1.0), activations 0x7FF, NUM_IN=64 -> all scores clamp to 0x800, class_idx=0, max_score=0x800.
- Address check: start pulse -> rom_addr==act_addr steps 0..NUM_IN-1 exactly once per cycle and each product pairs matching addresses. A second start pulse mid-sweep -> no restart, single done.
- Reset at cycle 20 of a sweep -> next cycle shows busy=0, rom_addr=0, class_idx=0, max_score=0, no done. A fresh start then reproduces the first test's result exactly.
